if_id_elastic_register: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake on both sides, a one-entry skid buffer, global memory stall (BUSYWAIT) and synchronous flush. It sits between the fetch stage and the decode stage. It replaces the fixed 3×32-bit latch with a stallable, flushable, back-pressure-capable stage. Throughput is one transfer per cycle with no combinational path from OUT_READY to IN_READY.

---
 rtl/if_id_elastic_register.sv | 96 +++++++++
 tb/tb_if_id_elastic_register.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_id_elastic_register.sv
// IF/ID pipeline stage: valid/ready on both sides with a one-entry skid buffer,
// global BUSYWAIT stall and synchronous FLUSH. IN_READY never depends on OUT_READY.
module if_id_elastic_register #(
    parameter int               WIDTH     = 96,
    parameter logic [WIDTH-1:0] NOP_VALUE = {32'h00000013, 64'd0}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [1:0]       OCCUPANCY
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_fire, out_fire;

    assign IN_READY  = (state != FULL) & ~BUSYWAIT & ~FLUSH;
    assign OUT_VALID = (state != EMPTY);
    assign OUT_DATA  = OUT_VALID ? main_q : NOP_VALUE;
    assign OCCUPANCY = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = OUT_VALID & OUT_READY & ~BUSYWAIT;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Flush outranks the stall; the stall otherwise freezes everything.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (FLUSH) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VALUE;
            skid_nxt  = NOP_VALUE;
        end else if (!BUSYWAIT) begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_nxt  = IN_DATA;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = IN_DATA;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        skid_nxt  = IN_DATA;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                        main_nxt  = NOP_VALUE;
                    end
                end
                FULL: begin
                    // Skid always holds the younger entry, so it moves up to main.
                    if (out_fire) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = NOP_VALUE;
                    skid_nxt  = NOP_VALUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_elastic_register.sv
// Bench for if_id_elastic_register: directed scenarios plus random traffic,
// all checked against a queue model of the stage's contents.
module tb_if_id_elastic_register;

    localparam int               W   = 96;
    localparam logic [W-1:0]     NOP = {32'h00000013, 64'd0};

    logic         CLK = 1'b0;
    logic         RESET, BUSYWAIT, FLUSH, IN_VALID, OUT_READY;
    logic [W-1:0] IN_DATA;
    logic         IN_READY, OUT_VALID;
    logic [W-1:0] OUT_DATA;
    logic [1:0]   OCCUPANCY;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] q[$];

    if_id_elastic_register #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OCCUPANCY(OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] p(input int a, input int b, input int c);
        return {a[31:0], b[31:0], c[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs already driven: check outputs
    // against the model, take one rising edge, advance the model.
    task automatic cyc();
        int  n;
        bit  of, inf;
        n = q.size();
        #1;
        chk("out_valid", OUT_VALID, n != 0);
        chk("out_data",  OUT_DATA,  n != 0 ? q[0] : NOP);
        chk("occupancy", OCCUPANCY, n);
        chk("in_ready",  IN_READY,  (n < 2) && !BUSYWAIT && !FLUSH);
        @(posedge CLK);
        if (RESET || FLUSH) q.delete();
        else if (!BUSYWAIT) begin
            of  = (n > 0) && OUT_READY;
            inf = IN_VALID && (n < 2);
            if (of)  void'(q.pop_front());
            if (inf) q.push_back(IN_DATA);
        end
        @(negedge CLK);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy, input bit bw, input bit fl);
        IN_VALID = v; IN_DATA = d; OUT_READY = rdy; BUSYWAIT = bw; FLUSH = fl;
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, '0, 0, 0, 0);
        #1;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_data",  OUT_DATA,  NOP);
        chk("rst_occupancy", OCCUPANCY, 2'd0);
        chk("rst_in_ready",  IN_READY,  1'b1);
        @(negedge CLK);
        RESET = 1'b0;

        // Single transfer
        drive(1, p(20, 56, 52), 1, 0, 0); cyc();
        drive(0, '0, 0, 0, 0);
        #1;
        chk("single_data",  OUT_DATA,  p(20, 56, 52));
        chk("single_valid", OUT_VALID, 1'b1);
        chk("single_occ",   OCCUPANCY, 2'd1);
        @(negedge CLK);

        // Stall: BUSYWAIT freezes the stage even with traffic offered
        for (int i = 0; i < 3; i++) begin
            drive(1, p(30, 64, 60), 1, 1, 0); cyc();
        end
        drive(0, '0, 0, 1, 0);
        #1;
        chk("stall_data",  OUT_DATA,  p(20, 56, 52));
        chk("stall_ready", IN_READY,  1'b0);
        chk("stall_occ",   OCCUPANCY, 2'd1);
        @(negedge CLK);

        // Skid: empty first, then stream with decode stalled
        drive(0, '0, 0, 0, 1); cyc();
        drive(1, p(20, 0, 0), 0, 0, 0); cyc();
        drive(1, p(30, 0, 0), 0, 0, 0); cyc();
        drive(1, p(40, 0, 0), 0, 0, 0); cyc();
        drive(1, p(40, 0, 0), 0, 0, 0); cyc();
        drive(1, p(40, 0, 0), 1, 0, 0); cyc();
        drive(1, p(40, 0, 0), 1, 0, 0); cyc();
        drive(0, '0, 1, 0, 0); cyc();
        drive(0, '0, 1, 0, 0); cyc();

        // Flush from FULL while stalled; flush-cycle payload must never appear
        drive(1, p(1, 1, 1), 0, 0, 0); cyc();
        drive(1, p(2, 2, 2), 0, 0, 0); cyc();
        drive(1, p(99, 99, 99), 1, 1, 1); cyc();
        drive(0, '0, 1, 0, 0);
        #1;
        chk("flush_valid", OUT_VALID, 1'b0);
        chk("flush_data",  OUT_DATA,  NOP);
        chk("flush_occ",   OCCUPANCY, 2'd0);
        @(negedge CLK);

        // Streaming 0..15 back-to-back
        for (int i = 0; i < 16; i++) begin
            drive(1, p(0, 0, i), 1, 0, 0); cyc();
            chk("stream_data", OUT_DATA, p(0, 0, i));
        end
        drive(0, '0, 1, 0, 0); cyc();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0);
            cyc();
        end

        // Asynchronous reset with two entries held
        drive(1, p(7, 7, 7), 0, 0, 0); cyc();
        drive(1, p(8, 8, 8), 0, 0, 0); cyc();
        chk("pre_rst_occ", OCCUPANCY, 2'd2);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_valid", OUT_VALID, 1'b0);
        chk("async_rst_data",  OUT_DATA,  NOP);
        chk("async_rst_occ",   OCCUPANCY, 2'd0);
        q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        drive(1, p(5, 6, 7), 1, 0, 0); cyc();
        drive(0, '0, 1, 0, 0); cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
